// File: rtl/sprite_draw_pkg.sv
// Shared constants for the sprite blitter: FSM encoding, screen geometry, colour key.
package sprite_draw_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int XW    = 8;
  localparam int YW    = 7;
  localparam int SCR_W = 160;
  localparam int SCR_H = 120;
  localparam logic [7:0] TRANSP = 8'hE3;
endpackage

// File: rtl/sprite_pix_pipe.sv
// Two-stage pixel path: align the (dx,dy,valid) tag with ROM data, then add origin and filter.
module sprite_pix_pipe #(
  parameter int DXW    = 5,
  parameter int DYW    = 5,
  parameter int DATA_W = 8,
  parameter int XW     = 8,
  parameter int YW     = 7,
  parameter int SCR_W  = 160,
  parameter int SCR_H  = 120,
  parameter logic [DATA_W-1:0] TRANSP = 8'hE3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tag_vld,
  input  logic [DXW-1:0]    tag_dx,
  input  logic [DYW-1:0]    tag_dy,
  input  logic [XW-1:0]     org_x,
  input  logic [YW-1:0]     org_y,
  input  logic [DATA_W-1:0] mem_data,
  output logic [XW-1:0]     plot_x,
  output logic [YW-1:0]     plot_y,
  output logic [DATA_W-1:0] plot_colour,
  output logic              plot
);
  logic           vld_s1;
  logic [DXW-1:0] dx_s1;
  logic [DYW-1:0] dy_s1;
  logic [XW:0]    sum_x;
  logic [YW:0]    sum_y;
  logic           on_scr;
  logic           opaque;

  // Extra sum bit keeps a carry visible so wrapped coordinates are clipped, not plotted.
  assign sum_x  = {1'b0, org_x} + (XW+1)'(dx_s1);
  assign sum_y  = {1'b0, org_y} + (YW+1)'(dy_s1);
  assign on_scr = (sum_x < (XW+1)'(SCR_W)) && (sum_y < (YW+1)'(SCR_H));
  assign opaque = (mem_data != TRANSP);

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_s1      <= 1'b0;
      dx_s1       <= '0;
      dy_s1       <= '0;
      plot_x      <= '0;
      plot_y      <= '0;
      plot_colour <= '0;
      plot        <= 1'b0;
    end else begin
      vld_s1      <= tag_vld;
      dx_s1       <= tag_dx;
      dy_s1       <= tag_dy;
      plot_x      <= sum_x[XW-1:0];
      plot_y      <= sum_y[YW-1:0];
      plot_colour <= mem_data;
      plot        <= vld_s1 && opaque && on_scr;
    end
  end
endmodule

// File: rtl/sprite_draw_ctrl.sv
// Sprite blit sequencer: Start/Done handshake, row-major ROM address walk, pixel pipe.
module sprite_draw_ctrl #(
  parameter int SPR_W  = 32,
  parameter int SPR_H  = 32,
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8,
  parameter int XW     = sprite_draw_pkg::XW,
  parameter int YW     = sprite_draw_pkg::YW,
  parameter int SCR_W  = sprite_draw_pkg::SCR_W,
  parameter int SCR_H  = sprite_draw_pkg::SCR_H,
  parameter logic [DATA_W-1:0] TRANSP = sprite_draw_pkg::TRANSP
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Start,
  input  logic [XW-1:0]     X0,
  input  logic [YW-1:0]     Y0,
  output logic              Busy,
  output logic              Done,
  output logic [ADDR_W-1:0] MemAddr,
  input  logic [DATA_W-1:0] MemData,
  output logic [XW-1:0]     PlotX,
  output logic [YW-1:0]     PlotY,
  output logic [DATA_W-1:0] PlotColour,
  output logic              Plot
);
  import sprite_draw_pkg::*;

  localparam int DXW = $clog2(SPR_W);
  localparam int DYW = $clog2(SPR_H);

  state_t         state_q, state_d;
  logic [DXW-1:0] dx_q;
  logic [DYW-1:0] dy_q;
  logic [XW-1:0]  x0_q;
  logic [YW-1:0]  y0_q;
  logic           drain_q;
  logic           last;

  assign last    = (dx_q == DXW'(SPR_W-1)) && (dy_q == DYW'(SPR_H-1));
  assign MemAddr = ADDR_W'({dy_q, dx_q});
  assign Busy    = (state_q == RUN) || (state_q == DRAIN);
  assign Done    = (state_q == DONE);

  always_ff @(posedge Clock) begin
    if (Reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (Start) state_d = RUN;
      RUN:     if (last) state_d = DRAIN;
      DRAIN:   if (drain_q) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Counters wrap back to zero after the last address, so MemAddr idles at 0.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      dx_q    <= '0;
      dy_q    <= '0;
      x0_q    <= '0;
      y0_q    <= '0;
      drain_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (Start) begin
          x0_q <= X0;
          y0_q <= Y0;
          dx_q <= '0;
          dy_q <= '0;
        end
        RUN: begin
          dx_q <= dx_q + 1'b1;
          if (dx_q == DXW'(SPR_W-1)) dy_q <= dy_q + 1'b1;
        end
        DRAIN:   drain_q <= ~drain_q;
        default: drain_q <= 1'b0;
      endcase
    end
  end

  sprite_pix_pipe #(
    .DXW(DXW), .DYW(DYW), .DATA_W(DATA_W), .XW(XW), .YW(YW),
    .SCR_W(SCR_W), .SCR_H(SCR_H), .TRANSP(TRANSP)
  ) u_pipe (
    .clk        (Clock),
    .rst        (Reset),
    .tag_vld    (state_q == RUN),
    .tag_dx     (dx_q),
    .tag_dy     (dy_q),
    .org_x      (x0_q),
    .org_y      (y0_q),
    .mem_data   (MemData),
    .plot_x     (PlotX),
    .plot_y     (PlotY),
    .plot_colour(PlotColour),
    .plot       (Plot)
  );
endmodule

// File: tb/tb_sprite_draw_ctrl.sv
// Directed bench for sprite_draw_ctrl with a registered-read ROM model.
module tb_sprite_draw_ctrl;
  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic       Start = 1'b0;
  logic [7:0] X0 = '0;
  logic [6:0] Y0 = '0;
  logic       Busy, Done, Plot;
  logic [9:0] MemAddr;
  logic [7:0] MemData = '0;
  logic [7:0] PlotX;
  logic [6:0] PlotY;
  logic [7:0] PlotColour;

  int checks = 0;
  int failures = 0;
  int rom_mode = 0;

  int plot_cnt, pix_err, pix_bad, busy_err, addr_err, done_cnt, first_plot, last_plot;
  int done_c[2];
  logic [9:0] addr1030;

  sprite_draw_ctrl dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .X0(X0), .Y0(Y0),
    .Busy(Busy), .Done(Done), .MemAddr(MemAddr), .MemData(MemData),
    .PlotX(PlotX), .PlotY(PlotY), .PlotColour(PlotColour), .Plot(Plot)
  );

  always #5 Clock = ~Clock;

  function automatic logic [7:0] rom(input int mode, input int a);
    if (mode == 1) return (a < 32) ? 8'hE3 : 8'h55;
    return 8'h11;
  endfunction

  always @(posedge Clock) MemData <= rom(rom_mode, int'(MemAddr));

  // Starts a draw now (cycle 0) and watches cycles 1..ncyc against a reference walk.
  task automatic observe(input int x0, input int y0, input int ncyc,
                         input int restart_at, input bit hold);
    int idx, ex, ey;
    bit ep;
    logic [7:0] ec;
    plot_cnt = 0; pix_err = 0; pix_bad = -1; busy_err = 0; addr_err = 0;
    done_cnt = 0; first_plot = -1; last_plot = -1; done_c[0] = -1; done_c[1] = -1;
    addr1030 = '1;
    X0 = 8'(x0); Y0 = 7'(y0); Start = 1'b1;
    for (int c = 1; c <= ncyc; c++) begin
      @(posedge Clock); #1;
      if (!hold && c == 1) Start = 1'b0;
      if (c == restart_at) begin Start = 1'b1; X0 = '0; Y0 = '0; end
      if (c == restart_at + 1) Start = 1'b0;
      if (c <= 1028) begin
        if (Busy !== 1'(c <= 1026)) busy_err++;
        if (c <= 1024 && MemAddr !== 10'(c - 1)) addr_err++;
        idx = c - 3; ep = 1'b0; ex = 0; ey = 0; ec = '0;
        if (idx >= 0 && idx < 1024) begin
          ex = x0 + idx % 32; ey = y0 + idx / 32; ec = rom(rom_mode, idx);
          ep = (ec != 8'hE3) && (ex < 160) && (ey < 120);
        end
        if (Plot !== ep ||
            (ep && (PlotX !== 8'(ex) || PlotY !== 7'(ey) || PlotColour !== ec))) begin
          pix_err++;
          if (pix_bad < 0) pix_bad = c;
        end
      end
      if (c == 1030) addr1030 = MemAddr;
      if (Plot === 1'b1) begin
        plot_cnt++;
        if (first_plot < 0) first_plot = c;
        last_plot = c;
      end
      if (Done === 1'b1) begin
        if (done_cnt < 2) done_c[done_cnt] = c;
        done_cnt++;
      end
    end
  endtask

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic test_reset;
    Reset = 1'b1;
    repeat (3) @(posedge Clock);
    #1;
    chk("reset_busy", int'(Busy), 0);
    chk("reset_done", int'(Done), 0);
    chk("reset_plot", int'(Plot), 0);
    chk("reset_addr", int'(MemAddr), 0);
    chk("reset_plotx", int'(PlotX), 0);
    chk("reset_ploty", int'(PlotY), 0);
    chk("reset_colour", int'(PlotColour), 0);
    Reset = 1'b0;
    @(posedge Clock); #1;
  endtask

  task automatic test_basic;
    rom_mode = 0;
    observe(10, 20, 1030, -1, 1'b0);
    chk("basic_plot_cnt", plot_cnt, 1024);
    chk("basic_first_plot", first_plot, 3);
    chk("basic_last_plot", last_plot, 1026);
    chk("basic_pix_err", pix_err, 0);
    chk("basic_busy_err", busy_err, 0);
    chk("basic_addr_err", addr_err, 0);
    chk("basic_done_cnt", done_cnt, 1);
    chk("basic_done_cyc", done_c[0], 1027);
  endtask

  task automatic test_transparent;
    rom_mode = 1;
    observe(10, 20, 1030, -1, 1'b0);
    chk("transp_plot_cnt", plot_cnt, 992);
    chk("transp_first_plot", first_plot, 35);
    chk("transp_pix_err", pix_err, 0);
    chk("transp_done_cyc", done_c[0], 1027);
    chk("transp_done_cnt", done_cnt, 1);
  endtask

  task automatic test_clip;
    rom_mode = 0;
    observe(150, 110, 1030, -1, 1'b0);
    chk("clip_plot_cnt", plot_cnt, 100);
    chk("clip_pix_err", pix_err, 0);
    chk("clip_done_cyc", done_c[0], 1027);
  endtask

  task automatic test_restart_ignored;
    rom_mode = 0;
    observe(10, 20, 1030, 500, 1'b0);
    chk("restart_pix_err", pix_err, 0);
    chk("restart_plot_cnt", plot_cnt, 1024);
    chk("restart_done_cnt", done_cnt, 1);
    chk("restart_done_cyc", done_c[0], 1027);
  endtask

  task automatic test_reset_mid;
    int early_done;
    early_done = 0;
    rom_mode = 0;
    X0 = 8'd10; Y0 = 7'd20; Start = 1'b1;
    for (int c = 1; c <= 300; c++) begin
      @(posedge Clock); #1;
      if (c == 1) Start = 1'b0;
      if (Done === 1'b1) early_done++;
    end
    Reset = 1'b1;
    @(posedge Clock); #1;
    chk("midrst_busy", int'(Busy), 0);
    chk("midrst_plot", int'(Plot), 0);
    chk("midrst_addr", int'(MemAddr), 0);
    if (Done === 1'b1) early_done++;
    Reset = 1'b0;
    for (int c = 302; c <= 305; c++) begin
      @(posedge Clock); #1;
      if (Done === 1'b1 || Plot === 1'b1) early_done++;
    end
    chk("midrst_no_done", early_done, 0);
    observe(10, 20, 1030, -1, 1'b0);
    chk("midrst_rerun_plot_cnt", plot_cnt, 1024);
    chk("midrst_rerun_pix_err", pix_err, 0);
    chk("midrst_rerun_done_cyc", done_c[0], 1027);
  endtask

  task automatic test_back_to_back;
    rom_mode = 0;
    observe(10, 20, 2060, -1, 1'b1);
    Start = 1'b0;
    chk("b2b_done0_cyc", done_c[0], 1027);
    chk("b2b_done1_cyc", done_c[1], 2055);
    chk("b2b_done_cnt", done_cnt, 2);
    chk("b2b_addr_1030", int'(addr1030), 1);
    chk("b2b_busy_err", busy_err, 0);
    chk("b2b_pix_err", pix_err, 0);
    Reset = 1'b1;
    @(posedge Clock); #1;
    Reset = 1'b0;
  endtask

  initial begin
    test_reset;
    test_basic;
    test_transparent;
    test_clip;
    test_restart_ignored;
    test_reset_mid;
    test_back_to_back;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
